// File: rtl/smg_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// hex segment table, segment bit positions and the all-off pattern.
package smg_pkg;

  // Segment bit positions within the 8-bit {dp,g,f,e,d,c,b,a} bus
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // All segments dark, active-high form (polarity is applied at the output register)
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high {g,f,e,d,c,b,a} patterns, indexed by nibble value (entry 15 listed first)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/smg_scan_multi.sv
// Multiplexed seven-segment scan controller for NUM_DIGITS hex digits.
// A prescaler sets the per-digit dwell; the first BLANK_CYCLES of each dwell
// keep every digit dark to suppress ghosting. New values are staged on load and
// moved into the displayed shadow copy only at a frame boundary (tear-free).
// Optional: define SMG_LEAD_ZERO_BLANK_EN to darken leading zero digits.
module smg_scan_multi
  import smg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          DIG_ACT_LOW  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] number_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic [NUM_DIGITS-1:0]   blank_mask_i,
  input  logic                    load_i,
  output logic                    pending_o,
  output logic                    frame_done_o,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o
);

  localparam int unsigned Div  = CLK_HZ / SCAN_HZ;
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned NumW = 4 * NUM_DIGITS;

  localparam logic [PreW-1:0] PreLast  = PreW'(Div - 1);
  localparam logic [PreW-1:0] PreBlank = PreW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  // Idle output levels with polarity applied
  localparam logic [7:0]            SegIdle = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DigIdle = DIG_ACT_LOW ? '1 : '0;

  logic [PreW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumW-1:0]       staged_num_q, staged_num_d;
  logic [NUM_DIGITS-1:0] staged_dp_q, staged_dp_d;
  logic [NUM_DIGITS-1:0] staged_blank_q, staged_blank_d;
  logic [NumW-1:0]       shadow_num_q, shadow_num_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic                  tick;
  logic                  frame_bnd;
  logic [3:0]            digit_nib;
  logic [6:0]            digit_pat;
  logic                  lead_dark;
  logic [7:0]            seg_act;
  logic [NUM_DIGITS-1:0] dig_act;

  assign tick      = (presc_q == PreLast);
  assign frame_bnd = tick && (idx_q == IdxLast);

  // Prescaler and digit index advance
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Staged/shadow handoff; a load landing on the boundary bypasses staging
  always_comb begin
    staged_num_d   = staged_num_q;
    staged_dp_d    = staged_dp_q;
    staged_blank_d = staged_blank_q;
    shadow_num_d   = shadow_num_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    pending_d      = pending_q;
    frame_done_d   = frame_bnd;
    if (load_i) begin
      if (frame_bnd) begin
        shadow_num_d   = number_i;
        shadow_dp_d    = dp_mask_i;
        shadow_blank_d = blank_mask_i;
        pending_d      = 1'b0;
      end else begin
        staged_num_d   = number_i;
        staged_dp_d    = dp_mask_i;
        staged_blank_d = blank_mask_i;
        pending_d      = 1'b1;
      end
    end else if (frame_bnd && pending_q) begin
      shadow_num_d   = staged_num_q;
      shadow_dp_d    = staged_dp_q;
      shadow_blank_d = staged_blank_q;
      pending_d      = 1'b0;
    end
  end

  assign digit_nib = shadow_num_q[{idx_q, 2'b00} +: 4];

  smg_hex_decode u_hex_decode (
    .nibble_i (digit_nib),
    .seg_o    (digit_pat)
  );

`ifdef SMG_LEAD_ZERO_BLANK_EN
  logic [IdxW-1:0] msd_idx;

  // Highest non-zero digit; stays 0 for a zero value so digit 0 always shows
  always_comb begin
    msd_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (shadow_num_q[4*i +: 4] != 4'h0) begin
        msd_idx = IdxW'(i);
      end
    end
  end

  assign lead_dark = (idx_q > msd_idx);
`else
  assign lead_dark = 1'b0;
`endif

  // Active-high output pattern for the current dwell position
  always_comb begin
    seg_act = SEG_OFF;
    dig_act = '0;
    if (presc_q >= PreBlank) begin
      dig_act[idx_q] = 1'b1;
      if (!shadow_blank_q[idx_q]) begin
        seg_act[SEG_DP] = shadow_dp_q[idx_q];
        if (!lead_dark) begin
          seg_act[SEG_G:SEG_A] = digit_pat;
        end
      end
    end
    seg_d     = SEG_ACT_LOW ? ~seg_act : seg_act;
    dig_sel_d = DIG_ACT_LOW ? ~dig_act : dig_act;
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q        <= '0;
      idx_q          <= '0;
      staged_num_q   <= '0;
      staged_dp_q    <= '0;
      staged_blank_q <= '0;
      shadow_num_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      pending_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      seg_q          <= SegIdle;
      dig_sel_q      <= DigIdle;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      staged_num_q   <= staged_num_d;
      staged_dp_q    <= staged_dp_d;
      staged_blank_q <= staged_blank_d;
      shadow_num_q   <= shadow_num_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      pending_q      <= pending_d;
      frame_done_q   <= frame_done_d;
      seg_q          <= seg_d;
      dig_sel_q      <= dig_sel_d;
    end
  end

  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;
  assign seg_o        = seg_q;
  assign dig_sel_o    = dig_sel_q;

endmodule

// File: tb/tb_smg_scan_multi.sv
// Bench for smg_scan_multi: 4 digits, DIV=10, 2 blank cycles, active-low outputs.
// A cycle-count model predicts every output each cycle; literal checkpoints pin
// both the DUT and the model at hand-computed points.
module tb_smg_scan_multi;

  localparam int Div   = 10;
  localparam int Nd    = 4;
  localparam int Blank = 2;
`ifdef SMG_LEAD_ZERO_BLANK_EN
  localparam bit Lz = 1'b1;
`else
  localparam bit Lz = 1'b0;
`endif
  // Expected pattern of a leading-zero digit in this build
  localparam logic [7:0] LzSeg = Lz ? 8'hFF : 8'hC0;

  logic        clk;
  logic        rst_n;
  logic [15:0] number;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        load;
  logic        pending;
  logic        frame_done;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;

  smg_scan_multi #(
    .NUM_DIGITS   (4),
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2),
    .SEG_ACT_LOW  (1'b1),
    .DIG_ACT_LOW  (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .number_i     (number),
    .dp_mask_i    (dp_mask),
    .blank_mask_i (blank_mask),
    .load_i       (load),
    .pending_o    (pending),
    .frame_done_o (frame_done),
    .seg_o        (seg),
    .dig_sel_o    (dig_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  int          t;          // clock edges since reset release
  logic [15:0] m_stag_num, m_shad_num;
  logic [3:0]  m_stag_dp, m_shad_dp, m_stag_bl, m_shad_bl;
  logic        m_pend;
  logic        exp_fd;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_dig;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic bit is_bnd(input int n);
    return (n % (Div * Nd)) == (Div * Nd - 1);
  endfunction

  // Output pattern {seg, dig_sel} (active-low) for the dwell position at count n
  function automatic logic [11:0] model_out(input int n, input logic [15:0] num,
                                            input logic [3:0] dp, input logic [3:0] bl);
    int         idx, pr, msd;
    logic [7:0] s;
    logic [3:0] d;
    idx = (n / Div) % Nd;
    pr  = n % Div;
    s   = 8'h00;
    d   = 4'h0;
    msd = 0;
    for (int i = 0; i < Nd; i++) if (num[4*i +: 4] != 4'h0) msd = i;
    if (pr >= Blank) begin
      d[idx] = 1'b1;
      if (!bl[idx]) begin
        s[7] = dp[idx];
        if (!(Lz && idx > msd)) s[6:0] = hex7(num[4*idx +: 4]);
      end
    end
    return {~s, ~d};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t          <= 0;
      m_stag_num <= '0; m_stag_dp <= '0; m_stag_bl <= '0;
      m_shad_num <= '0; m_shad_dp <= '0; m_shad_bl <= '0;
      m_pend     <= 1'b0;
      exp_fd     <= 1'b0;
      exp_seg    <= 8'hFF;
      exp_dig    <= 4'hF;
    end else begin
      {exp_seg, exp_dig} <= model_out(t, m_shad_num, m_shad_dp, m_shad_bl);
      exp_fd <= is_bnd(t);
      t      <= t + 1;
      if (load) begin
        if (is_bnd(t)) begin
          m_shad_num <= number; m_shad_dp <= dp_mask; m_shad_bl <= blank_mask;
          m_pend     <= 1'b0;
        end else begin
          m_stag_num <= number; m_stag_dp <= dp_mask; m_stag_bl <= blank_mask;
          m_pend     <= 1'b1;
        end
      end else if (is_bnd(t) && m_pend) begin
        m_shad_num <= m_stag_num; m_shad_dp <= m_stag_dp; m_shad_bl <= m_stag_bl;
        m_pend     <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  int    n_checks = 0;
  int    n_errors = 0;
  bit    chk_en   = 1'b0;
  bit    lit_en   = 1'b0;
  string lit_name = "";
  logic [7:0] lit_seg;
  logic [3:0] lit_dig;
  logic       lit_pend, lit_fd;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got %h, expected %h", nm, t, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("seg", seg, exp_seg);
      cmp("dig_sel", {4'h0, dig_sel}, {4'h0, exp_dig});
      cmp("pending", {7'h0, pending}, {7'h0, m_pend});
      cmp("frame_done", {7'h0, frame_done}, {7'h0, exp_fd});
      if (lit_en) begin
        cmp({lit_name, "/seg"}, seg, lit_seg);
        cmp({lit_name, "/dig_sel"}, {4'h0, dig_sel}, {4'h0, lit_dig});
        cmp({lit_name, "/pending"}, {7'h0, pending}, {7'h0, lit_pend});
        cmp({lit_name, "/frame_done"}, {7'h0, frame_done}, {7'h0, lit_fd});
        cmp({lit_name, "/model_seg"}, exp_seg, lit_seg);
        cmp({lit_name, "/model_dig"}, {4'h0, exp_dig}, {4'h0, lit_dig});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_n(input int n);
    while (t < n) @(negedge clk);
  endtask

  task automatic set_lit(input string nm, input logic [7:0] s, input logic [3:0] d,
                         input logic p, input logic f);
    lit_name = nm; lit_seg = s; lit_dig = d; lit_pend = p; lit_fd = f;
    lit_en   = 1'b1;
  endtask

  // Literal expectation for the outputs seen after the next clock edge
  task automatic lit_now(input string nm, input logic [7:0] s, input logic [3:0] d,
                         input logic p, input logic f);
    @(posedge clk);
    #1 set_lit(nm, s, d, p, f);
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  // Literal expectation for the outputs after edge n
  task automatic lit_at(input int n, input string nm, input logic [7:0] s,
                        input logic [3:0] d, input logic p, input logic f);
    wait_n(n - 1);
    lit_now(nm, s, d, p, f);
  endtask

  task automatic do_load(input logic [15:0] num, input logic [3:0] dp, input logic [3:0] bl);
    number = num; dp_mask = dp; blank_mask = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    number = '0; dp_mask = '0; blank_mask = '0; load = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    lit_now("reset_held", 8'hFF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First dwell: digit 0 appears on the third edge
    lit_at(2, "dwell_blank", 8'hFF, 4'hF, 1'b0, 1'b0);
    lit_at(3, "dwell_first", 8'hC0, 4'hE, 1'b0, 1'b0);

    // Staged load, applied at the boundary
    wait_n(10);
    do_load(16'h12AF, 4'h0, 4'h0);
    lit_at(39, "pend_hold", LzSeg, 4'h7, 1'b1, 1'b0);
    lit_at(40, "bnd_apply", LzSeg, 4'h7, 1'b0, 1'b1);
    lit_at(45, "d0_F", 8'h8E, 4'hE, 1'b0, 1'b0);
    lit_at(75, "d3_1", 8'hF9, 4'h7, 1'b0, 1'b0);
    lit_at(80, "bnd2", 8'hF9, 4'h7, 1'b0, 1'b1);

    // Two loads before a boundary: last wins
    wait_n(85);
    do_load(16'h1111, 4'h0, 4'h0);
    lit_at(86, "first_load", 8'h8E, 4'hE, 1'b1, 1'b0);
    wait_n(100);
    do_load(16'h0003, 4'h0, 4'h0);
    lit_at(102, "second_load", 8'hFF, 4'hF, 1'b1, 1'b0);
    lit_at(120, "bnd3", 8'hF9, 4'h7, 1'b0, 1'b1);
    lit_at(125, "d0_3", 8'hB0, 4'hE, 1'b0, 1'b0);
    lit_at(135, "d1_0", LzSeg, 4'hD, 1'b0, 1'b0);

    // Load exactly on the boundary cycle
    wait_n(159);
    do_load(16'h5555, 4'h0, 4'h0);
    lit_at(163, "bnd_load", 8'h92, 4'hE, 1'b0, 1'b0);

    // Decimal point and blanking
    wait_n(170);
    do_load(16'h4321, 4'b0100, 4'b1000);
    lit_at(225, "d2_dp", 8'h30, 4'hB, 1'b0, 1'b0);
    lit_at(235, "d3_blank", 8'hFF, 4'h7, 1'b0, 1'b0);

    // Leading zeros
    wait_n(240);
    do_load(16'h0040, 4'h0, 4'h0);
    lit_at(285, "lz_d0", 8'hC0, 4'hE, 1'b0, 1'b0);
    lit_at(295, "lz_d1", 8'h99, 4'hD, 1'b0, 1'b0);
    lit_at(305, "lz_d2", LzSeg, 4'hB, 1'b0, 1'b0);
    lit_at(315, "lz_d3", LzSeg, 4'h7, 1'b0, 1'b0);
    wait_n(320);
    do_load(16'h0000, 4'h0, 4'h0);
    lit_at(365, "zero_d0", 8'hC0, 4'hE, 1'b0, 1'b0);
    lit_at(375, "zero_d1", LzSeg, 4'hD, 1'b0, 1'b0);

    // Reset mid-dwell with staged data outstanding
    wait_n(380);
    do_load(16'hABCD, 4'h0, 4'h0);
    wait_n(392);
    @(posedge clk);
    #2 rst_n = 1'b0;
    set_lit("rst_mid", 8'hFF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    #1 lit_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lit_at(3, "post_rst", 8'hC0, 4'hE, 1'b0, 1'b0);
    lit_at(45, "staged_lost", 8'hC0, 4'hE, 1'b0, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
